// File: rtl/pri_arb.sv
// Request arbiter with a single registered grant slot.
// Picks one requester per free slot, either by fixed priority (highest index
// wins) or round robin starting just below the last accepted index, and counts
// accepted grants.
module pri_arb #(
  parameter int N  = 8,
  parameter int W  = 3,
  parameter int RR = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         out_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_oh,
  output logic [15:0]  gnt_cnt
);

  logic         vld_q,  vld_d;
  logic [W-1:0] idx_q,  idx_d;
  logic [N-1:0] oh_q,   oh_d;
  logic [15:0]  cnt_q,  cnt_d;
  logic [W-1:0] last_q, last_d;

  logic         accept;
  logic         slot_free;
  logic [W-1:0] base;
  logic [W-1:0] pick;
  logic [W-1:0] cand_w;
  int           cand;

  assign accept    = vld_q & out_rdy;
  assign slot_free = ~vld_q | out_rdy;

  // Winner selection. In round robin the search starts below the index being
  // accepted this cycle so back-to-back grants rotate without an idle cycle.
  // Both loops run lowest-priority first so the last hit is the winner.
  always_comb begin
    pick   = '0;
    cand   = 0;
    cand_w = '0;
    base   = accept ? idx_q : last_q;
    if (RR == 0) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) pick = W'(i);
      end
    end else begin
      for (int k = N; k >= 1; k--) begin
        cand = int'(base) - k;
        if (cand < 0) cand = cand + N;
        cand_w = W'(cand);
        if (req[cand_w]) pick = cand_w;
      end
    end
  end

  // Next state: the slot reloads only when free; a stalled grant holds and
  // ignores req. The last-accepted index moves only on an accept.
  always_comb begin
    vld_d  = vld_q;
    idx_d  = idx_q;
    oh_d   = oh_q;
    cnt_d  = cnt_q;
    last_d = last_q;
    if (accept) begin
      cnt_d  = cnt_q + 16'd1;
      last_d = idx_q;
    end
    if (slot_free) begin
      vld_d = |req;
      oh_d  = '0;
      if (|req) begin
        idx_d       = pick;
        oh_d[pick]  = 1'b1;
      end
    end
  end

  // State registers; reset overrides any grant accepted in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      idx_q  <= '0;
      oh_q   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      vld_q  <= vld_d;
      idx_q  <= idx_d;
      oh_q   <= oh_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  assign out_vld = vld_q;
  assign out_idx = idx_q;
  assign out_oh  = oh_q;
  assign gnt_cnt = cnt_q;

endmodule

// File: tb/tb_pri_arb.sv
// Directed bench for pri_arb: one fixed-priority and one round-robin instance.
module tb_pri_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req_f = '0, req_r = '0;
  logic       rdy_f = 1'b0, rdy_r = 1'b0;
  logic       vld_f, vld_r;
  logic [2:0] idx_f, idx_r;
  logic [7:0] oh_f, oh_r;
  logic [15:0] cnt_f, cnt_r;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pri_arb #(.N(8), .W(3), .RR(0)) u_fp (
    .clk(clk), .rst(rst), .req(req_f), .out_rdy(rdy_f),
    .out_vld(vld_f), .out_idx(idx_f), .out_oh(oh_f), .gnt_cnt(cnt_f)
  );

  pri_arb #(.N(8), .W(3), .RR(1)) u_rr (
    .clk(clk), .rst(rst), .req(req_r), .out_rdy(rdy_r),
    .out_vld(vld_r), .out_idx(idx_r), .out_oh(oh_r), .gnt_cnt(cnt_r)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req_f = 8'hFF; req_r = 8'hFF; rdy_f = 1'b1; rdy_r = 1'b1;
    rst = 1'b1;
    step();
    step();
    checks++; if (vld_f !== 1'b0)  begin errors++; $display("FAIL rst_vld_f got %0b want 0", vld_f); end
    checks++; if (idx_f !== 3'd0)  begin errors++; $display("FAIL rst_idx_f got %0d want 0", idx_f); end
    checks++; if (oh_f !== 8'h00)  begin errors++; $display("FAIL rst_oh_f got %h want 00", oh_f); end
    checks++; if (cnt_f !== 16'd0) begin errors++; $display("FAIL rst_cnt_f got %0d want 0", cnt_f); end
    checks++; if (vld_r !== 1'b0)  begin errors++; $display("FAIL rst_vld_r got %0b want 0", vld_r); end
    checks++; if (idx_r !== 3'd0)  begin errors++; $display("FAIL rst_idx_r got %0d want 0", idx_r); end
    checks++; if (oh_r !== 8'h00)  begin errors++; $display("FAIL rst_oh_r got %h want 00", oh_r); end
    checks++; if (cnt_r !== 16'd0) begin errors++; $display("FAIL rst_cnt_r got %0d want 0", cnt_r); end
    req_f = '0; req_r = '0;
  endtask

  task automatic test_fixed();
    logic [7:0]  rv [8] = '{8'h2C, 8'h00, 8'h01, 8'hFF, 8'h41, 8'h90, 8'h06, 8'h00};
    logic        ev [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0]  ei [8] = '{3'd5, 3'd5, 3'd0, 3'd7, 3'd6, 3'd7, 3'd2, 3'd2};
    logic [15:0] ec [8] = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
    logic [7:0]  eoh;
    do_reset();
    rdy_f = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_f = rv[i];
      step();
      eoh = ev[i] ? (8'h01 << ei[i]) : 8'h00;
      checks++; if (vld_f !== ev[i]) begin errors++; $display("FAIL fixed_vld[%0d] got %0b want %0b", i, vld_f, ev[i]); end
      checks++; if (idx_f !== ei[i]) begin errors++; $display("FAIL fixed_idx[%0d] got %0d want %0d", i, idx_f, ei[i]); end
      checks++; if (oh_f !== eoh)    begin errors++; $display("FAIL fixed_oh[%0d] got %h want %h", i, oh_f, eoh); end
      checks++; if (cnt_f !== ec[i]) begin errors++; $display("FAIL fixed_cnt[%0d] got %0d want %0d", i, cnt_f, ec[i]); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    req_f = 8'h40; rdy_f = 1'b1;
    step();
    checks++; if (idx_f !== 3'd6 || vld_f !== 1'b1) begin errors++; $display("FAIL stall_first got vld=%0b idx=%0d want vld=1 idx=6", vld_f, idx_f); end
    rdy_f = 1'b0; req_f = 8'h01;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (vld_f !== 1'b1 || idx_f !== 3'd6 || oh_f !== 8'h40) begin errors++; $display("FAIL stall_hold[%0d] got vld=%0b idx=%0d oh=%h want vld=1 idx=6 oh=40", i, vld_f, idx_f, oh_f); end
      checks++; if (cnt_f !== 16'd0) begin errors++; $display("FAIL stall_cnt[%0d] got %0d want 0", i, cnt_f); end
    end
    rdy_f = 1'b1;
    step();
    checks++; if (vld_f !== 1'b1 || idx_f !== 3'd0 || oh_f !== 8'h01) begin errors++; $display("FAIL stall_release got vld=%0b idx=%0d oh=%h want vld=1 idx=0 oh=01", vld_f, idx_f, oh_f); end
    checks++; if (cnt_f !== 16'd1) begin errors++; $display("FAIL stall_release_cnt got %0d want 1", cnt_f); end
    req_f = 8'h00;
  endtask

  task automatic test_rr_all();
    logic [2:0] seq [9] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
    do_reset();
    req_r = 8'hFF; rdy_r = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      checks++; if (vld_r !== 1'b1 || idx_r !== seq[i]) begin errors++; $display("FAIL rr_all_idx[%0d] got vld=%0b idx=%0d want vld=1 idx=%0d", i, vld_r, idx_r, seq[i]); end
      checks++; if (oh_r !== (8'h01 << seq[i])) begin errors++; $display("FAIL rr_all_oh[%0d] got %h want %h", i, oh_r, 8'h01 << seq[i]); end
      checks++; if (cnt_r !== 16'(i)) begin errors++; $display("FAIL rr_all_cnt[%0d] got %0d want %0d", i, cnt_r, i); end
    end
    req_r = 8'h00;
  endtask

  task automatic test_rr_alt();
    do_reset();
    req_r = 8'h82; rdy_r = 1'b1;
    step();
    checks++; if (idx_r !== 3'd7 || cnt_r !== 16'd0) begin errors++; $display("FAIL rr_alt_0 got idx=%0d cnt=%0d want idx=7 cnt=0", idx_r, cnt_r); end
    step();
    checks++; if (idx_r !== 3'd1 || cnt_r !== 16'd1) begin errors++; $display("FAIL rr_alt_1 got idx=%0d cnt=%0d want idx=1 cnt=1", idx_r, cnt_r); end
    rdy_r = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (vld_r !== 1'b1 || idx_r !== 3'd1 || cnt_r !== 16'd1) begin errors++; $display("FAIL rr_alt_hold[%0d] got vld=%0b idx=%0d cnt=%0d want vld=1 idx=1 cnt=1", i, vld_r, idx_r, cnt_r); end
    end
    rdy_r = 1'b1;
    step();
    checks++; if (idx_r !== 3'd7 || cnt_r !== 16'd2) begin errors++; $display("FAIL rr_alt_2 got idx=%0d cnt=%0d want idx=7 cnt=2", idx_r, cnt_r); end
    step();
    checks++; if (idx_r !== 3'd1 || cnt_r !== 16'd3) begin errors++; $display("FAIL rr_alt_3 got idx=%0d cnt=%0d want idx=1 cnt=3", idx_r, cnt_r); end
    req_r = 8'h00;
    step();
    checks++; if (vld_r !== 1'b0 || oh_r !== 8'h00 || idx_r !== 3'd1 || cnt_r !== 16'd4) begin errors++; $display("FAIL rr_alt_idle got vld=%0b oh=%h idx=%0d cnt=%0d want vld=0 oh=00 idx=1 cnt=4", vld_r, oh_r, idx_r, cnt_r); end
    req_r = 8'h03;
    step();
    checks++; if (vld_r !== 1'b1 || idx_r !== 3'd0) begin errors++; $display("FAIL rr_alt_last got vld=%0b idx=%0d want vld=1 idx=0", vld_r, idx_r); end
    step();
    checks++; if (idx_r !== 3'd1 || cnt_r !== 16'd5) begin errors++; $display("FAIL rr_alt_wrap got idx=%0d cnt=%0d want idx=1 cnt=5", idx_r, cnt_r); end
    req_r = 8'h00;
  endtask

  task automatic test_rr_single();
    do_reset();
    req_r = 8'h10; rdy_r = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (vld_r !== 1'b1 || idx_r !== 3'd4 || cnt_r !== 16'(i)) begin errors++; $display("FAIL rr_single[%0d] got vld=%0b idx=%0d cnt=%0d want vld=1 idx=4 cnt=%0d", i, vld_r, idx_r, cnt_r, i); end
    end
    req_r = 8'h00;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_r = 8'hFF; rdy_r = 1'b1;
    step();
    step();
    checks++; if (idx_r !== 3'd6 || cnt_r !== 16'd1) begin errors++; $display("FAIL mid_pre got idx=%0d cnt=%0d want idx=6 cnt=1", idx_r, cnt_r); end
    rst = 1'b1;
    step();
    checks++; if (vld_r !== 1'b0 || cnt_r !== 16'd0 || oh_r !== 8'h00 || idx_r !== 3'd0) begin errors++; $display("FAIL mid_rst got vld=%0b cnt=%0d oh=%h idx=%0d want vld=0 cnt=0 oh=00 idx=0", vld_r, cnt_r, oh_r, idx_r); end
    rst = 1'b0;
    step();
    checks++; if (vld_r !== 1'b1 || idx_r !== 3'd7 || cnt_r !== 16'd0) begin errors++; $display("FAIL mid_first got vld=%0b idx=%0d cnt=%0d want vld=1 idx=7 cnt=0", vld_r, idx_r, cnt_r); end
    req_r = 8'h00;
  endtask

  task automatic test_wrap();
    do_reset();
    req_f = 8'h01; rdy_f = 1'b1;
    step();
    checks++; if (vld_f !== 1'b1 || cnt_f !== 16'd0) begin errors++; $display("FAIL wrap_start got vld=%0b cnt=%0d want vld=1 cnt=0", vld_f, cnt_f); end
    repeat (65535) @(posedge clk);
    #1;
    checks++; if (cnt_f !== 16'hFFFF) begin errors++; $display("FAIL wrap_full got %h want ffff", cnt_f); end
    step();
    checks++; if (cnt_f !== 16'h0000 || vld_f !== 1'b1 || idx_f !== 3'd0) begin errors++; $display("FAIL wrap_zero got cnt=%h vld=%0b idx=%0d want cnt=0000 vld=1 idx=0", cnt_f, vld_f, idx_f); end
    req_f = 8'h00;
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_stall();
    test_rr_all();
    test_rr_alt();
    test_rr_single();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
